booth_stream_decoder: RTL and testbench

//  Other end of the NTT/FIR Booth stream: consumes the per-lane radix-4 Booth control bits
//  (one/onen/two/twon) emitted digit-serially, LSB digit first, one digit slot per beat.

---
 rtl/booth_stream_pkg.sv | 21 ++
 rtl/booth_digit_dec.sv | 28 ++
 rtl/booth_stream_decoder.sv | 126 ++++++++++++
 tb/tb_booth_stream_decoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_stream_pkg.sv
// Shared definitions for the Booth digit stream: digit encodings, default
// geometry and the accumulator width helper.
package booth_stream_pkg;

    localparam logic signed [2:0] D_ZERO = 3'sd0;
    localparam logic signed [2:0] D_POS1 = 3'sd1;
    localparam logic signed [2:0] D_NEG1 = -3'sd1;
    localparam logic signed [2:0] D_POS2 = 3'sd2;
    localparam logic signed [2:0] D_NEG2 = -3'sd2;

    localparam int LANES_DEF  = 64;
    localparam int SLOTS_DEF  = 8;
    localparam int DIGITS_DEF = 6;
    localparam int WPB_DEF    = 4;

    // Radix-4 digits in -2..+2 over DIGITS positions fit in 2*DIGITS+1 signed bits.
    function automatic int acc_w(input int digits);
        return 2 * digits + 1;
    endfunction

endpackage

// File: rtl/booth_digit_dec.sv
// Per-lane radix-4 Booth control decode: one-hot {one,onen,two,twon} to a
// signed digit; any multi-hot combination yields digit 0 and flags illegal.
module booth_digit_dec
    import booth_stream_pkg::*;
(
    input  logic              one,
    input  logic              onen,
    input  logic              two,
    input  logic              twon,
    output logic signed [2:0] digit,
    output logic              illegal
);

    // Decode the control bits; all-low is a legal zero digit.
    always_comb begin
        digit   = D_ZERO;
        illegal = 1'b0;
        case ({one, onen, two, twon})
            4'b0000: digit = D_ZERO;
            4'b1000: digit = D_POS1;
            4'b0100: digit = D_NEG1;
            4'b0010: digit = D_POS2;
            4'b0001: digit = D_NEG2;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth_stream_decoder.sv
// Rebuilds per-lane signed words from a digit-serial Booth control stream
// (LSB digit first) and streams completed frames out WPB words per beat.
module booth_stream_decoder
    import booth_stream_pkg::*;
#(
    parameter  int LANES  = LANES_DEF,
    parameter  int SLOTS  = SLOTS_DEF,
    parameter  int DIGITS = DIGITS_DEF,
    parameter  int WPB    = WPB_DEF,
    localparam int ACC_W  = acc_w(DIGITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       one,
    input  logic [LANES-1:0]       onen,
    input  logic [LANES-1:0]       two,
    input  logic [LANES-1:0]       twon,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WPB*ACC_W-1:0]   dout,
    output logic                   out_last,
    output logic                   err
);

    localparam int NBEATS = LANES / WPB;
    localparam int SW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(NBEATS - 1);

    logic [SW-1:0]             slot;
    logic [BW-1:0]             beat_idx;
    logic                      obuf_full;
    logic                      err_q;
    logic signed [ACC_W-1:0]   acc      [LANES];
    logic signed [ACC_W-1:0]   acc_next [LANES];
    logic signed [ACC_W-1:0]   obuf     [LANES];
    logic signed [2:0]         dig      [LANES];
    logic [LANES-1:0]          ill;
    logic                      illegal_hit;
    logic                      digit_slot;
    logic                      accept;
    logic                      release_last;
    logic [SW:0]               shamt;

    for (genvar g = 0; g < LANES; g++) begin : g_dec
        booth_digit_dec u_dec (
            .one     (one[g]),
            .onen    (onen[g]),
            .two     (two[g]),
            .twon    (twon[g]),
            .digit   (dig[g]),
            .illegal (ill[g])
        );
    end

    // The final input beat may land in the same cycle obuf releases its last word.
    assign release_last = obuf_full && out_ready && (beat_idx == BEAT_LAST);
    assign in_ready     = !((slot == SLOT_LAST) && obuf_full && !release_last);
    assign accept       = in_valid && in_ready;
    assign digit_slot   = (32'(slot) < DIGITS);
    assign shamt        = {slot, 1'b0};

    // Next accumulator values: slot 0 restarts the lane sum, ignored slots hold it.
    always_comb begin
        illegal_hit = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            acc_next[i] = acc[i];
            if (digit_slot) begin
                acc_next[i] = ((slot == '0) ? '0 : acc[i])
                            + ({{(ACC_W-3){dig[i][2]}}, dig[i]} << shamt);
                if (ill[i]) illegal_hit = 1'b1;
            end
        end
    end

    // Slot counter, accumulators, output buffer hand-off, beat counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= '0;
            beat_idx  <= '0;
            obuf_full <= 1'b0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                acc[i]  <= '0;
                obuf[i] <= '0;
            end
        end else begin
            if (accept) begin
                slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                for (int unsigned i = 0; i < LANES; i++) acc[i] <= acc_next[i];
                if (illegal_hit) err_q <= 1'b1;
            end
            if (accept && (slot == SLOT_LAST)) begin
                for (int unsigned i = 0; i < LANES; i++) obuf[i] <= acc_next[i];
                obuf_full <= 1'b1;
                beat_idx  <= '0;
            end else if (obuf_full && out_ready) begin
                if (beat_idx == BEAT_LAST) begin
                    obuf_full <= 1'b0;
                    beat_idx  <= '0;
                end else begin
                    beat_idx <= beat_idx + 1'b1;
                end
            end
        end
    end

    // Output word mux: lane beat*WPB+w lands in word w, zero when idle.
    always_comb begin
        dout = '0;
        if (obuf_full) begin
            for (int unsigned w = 0; w < WPB; w++) begin
                dout[w*ACC_W +: ACC_W] = obuf[LW'(32'(beat_idx) * WPB + w)];
            end
        end
    end

    assign out_valid = obuf_full;
    assign out_last  = obuf_full && (beat_idx == BEAT_LAST);
    assign err       = err_q;

endmodule

// File: tb/tb_booth_stream_decoder.sv
// Directed self-checking bench for booth_stream_decoder.
module tb_booth_stream_decoder;

    localparam int LANES = 64;
    localparam int WPB   = 4;
    localparam int ACC_W = 13;
    localparam int NB    = LANES / WPB;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES-1:0]     one, onen, two, twon;
    logic                 out_valid;
    logic                 out_ready;
    logic [WPB*ACC_W-1:0] dout;
    logic                 out_last;
    logic                 err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_lane [LANES];
    logic [LANES-1:0] po [8];
    logic [LANES-1:0] pon [8];
    logic [LANES-1:0] pt [8];
    logic [LANES-1:0] ptn [8];

    always #5 clk = ~clk;

    booth_stream_decoder #(
        .LANES  (64),
        .SLOTS  (8),
        .DIGITS (6),
        .WPB    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .one       (one),
        .onen      (onen),
        .two       (two),
        .twon      (twon),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_last  (out_last),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_pat();
        for (int s = 0; s < 8; s++) begin
            po[s] = '0; pon[s] = '0; pt[s] = '0; ptn[s] = '0;
        end
    endtask

    task automatic set_exp(input int v);
        for (int l = 0; l < LANES; l++) exp_lane[l] = v;
    endtask

    function automatic logic [WPB*ACC_W-1:0] exp_word(input int b);
        logic [WPB*ACC_W-1:0] w;
        logic [31:0] v;
        w = '0;
        for (int k = 0; k < WPB; k++) begin
            v = exp_lane[b*WPB + k];
            w[k*ACC_W +: ACC_W] = v[ACC_W-1:0];
        end
        return w;
    endfunction

    task automatic send_slots(input int lo, input int hi);
        int n;
        for (int s = lo; s <= hi; s++) begin
            in_valid = 1'b1;
            one = po[s]; onen = pon[s]; two = pt[s]; twon = ptn[s];
            n = 0;
            while (in_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("accept_s%0d", s), 64'(in_ready), 64'(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        one = '0; onen = '0; two = '0; twon = '0;
    endtask

    task automatic drain(input bit expect_empty);
        out_ready = 1'b1;
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("valid_b%0d", b), 64'(out_valid), 64'(1));
            chk($sformatf("last_b%0d", b), 64'(out_last), 64'(b == NB-1));
            chk($sformatf("dout_b%0d", b), 64'(dout), 64'(exp_word(b)));
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (expect_empty) chk("valid_after_drain", 64'(out_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        one = '0; onen = '0; two = '0; twon = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last",  64'(out_last),  64'(0));
        chk("rst_dout",      64'(dout),      64'(0));
        chk("rst_err",       64'(err),       64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(1));

        // 1: lane0 = 1 + (-2)*4 = -7
        clear_pat();
        po[0][0]  = 1'b1;
        ptn[1][0] = 1'b1;
        set_exp(0);
        exp_lane[0] = -7;
        send_slots(0, 6);
        chk("t1_valid_before_last", 64'(out_valid), 64'(0));
        send_slots(7, 7);
        chk("t1_valid_latency", 64'(out_valid), 64'(1));
        chk("t1_dout_word0", 64'(dout[ACC_W-1:0]), 64'(13'h1FF9));
        drain(1'b1);

        // 2: all two -> 2730, all onen -> -1365
        clear_pat();
        for (int s = 0; s < 6; s++) pt[s] = '1;
        set_exp(2730);
        send_slots(0, 7);
        drain(1'b1);
        clear_pat();
        for (int s = 0; s < 6; s++) pon[s] = '1;
        set_exp(-1365);
        send_slots(0, 7);
        chk("t2_word_neg", 64'(dout[ACC_W-1:0]), 64'(13'h1AAB));
        drain(1'b1);

        // 3: ignored slots contribute nothing
        clear_pat();
        ptn[6] = '1;
        ptn[7] = '1;
        set_exp(0);
        send_slots(0, 7);
        drain(1'b1);
        chk("t3_err_clear", 64'(err), 64'(0));

        // 4: back-to-back frames under backpressure
        clear_pat();
        po[0][0]  = 1'b1;
        ptn[1][0] = 1'b1;
        set_exp(0);
        exp_lane[0] = -7;
        send_slots(0, 7);
        clear_pat();
        for (int s = 0; s < 6; s++) pt[s] = '1;
        send_slots(0, 6);
        in_valid = 1'b1;
        one = '0; onen = '0; two = '0; twon = '0;
        for (int c = 0; c < 13; c++) begin
            chk($sformatf("t4_stall_c%0d", c), 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        chk("t4_hold_valid", 64'(out_valid), 64'(1));
        chk("t4_hold_last",  64'(out_last),  64'(0));
        chk("t4_hold_dout",  64'(dout),      64'(exp_word(0)));
        out_ready = 1'b1;
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("t4_f1_dout_b%0d", b), 64'(dout), 64'(exp_word(b)));
            chk($sformatf("t4_f1_last_b%0d", b), 64'(out_last), 64'(b == NB-1));
            chk($sformatf("t4_ready_b%0d", b), 64'(in_ready), 64'(b == NB-1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        set_exp(2730);
        drain(1'b1);

        // 5: lane3 one&two at slot2 is illegal, digit 0; err sticky
        clear_pat();
        po[0][3] = 1'b1;
        po[2][3] = 1'b1;
        pt[2][3] = 1'b1;
        set_exp(0);
        exp_lane[3] = 1;
        send_slots(0, 7);
        chk("t5_err_set", 64'(err), 64'(1));
        drain(1'b1);
        clear_pat();
        set_exp(0);
        send_slots(0, 7);
        drain(1'b1);
        chk("t5_err_held", 64'(err), 64'(1));

        // 6: reset mid-frame with 5 beats pending
        clear_pat();
        for (int s = 0; s < 6; s++) pt[s] = '1;
        set_exp(2730);
        send_slots(0, 7);
        send_slots(0, 3);
        out_ready = 1'b1;
        repeat (11) @(negedge clk);
        out_ready = 1'b0;
        chk("t6_pending_valid", 64'(out_valid), 64'(1));
        chk("t6_pending_last",  64'(out_last),  64'(0));
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_dout",  64'(dout),      64'(0));
        chk("t6_rst_err",   64'(err),       64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", 64'(in_ready), 64'(1));
        clear_pat();
        for (int s = 0; s < 6; s++) pon[s] = '1;
        set_exp(-1365);
        send_slots(0, 7);
        drain(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
